// File: rtl/dbscan_pkg.sv
// Shared definitions for the DBSCAN post-processing blocks: sizes, FSM states
// and the per-cluster bounding-box record.
package dbscan_pkg;

    localparam int N_POINTS     = 9;
    localparam int ADDR_W       = 4;
    localparam int COORD_W      = 8;
    localparam int LABEL_W      = 4;
    localparam int MAX_CLUSTERS = 8;
    localparam int CNT_W        = 4;
    localparam int NOISE_LABEL  = 0;
    localparam int IDX_W        = $clog2(MAX_CLUSTERS);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        EMIT,
        FIN
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0]   count;
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] ymax;
        logic [COORD_W-1:0] zmin;
        logic [COORD_W-1:0] zmax;
    } bbox_t;

    // Empty entry: mins start at all-ones so the first point always replaces them
    function automatic bbox_t bbox_empty();
        bbox_t b;
        b.count = '0;
        b.xmin  = '1;
        b.xmax  = '0;
        b.ymin  = '1;
        b.ymax  = '0;
        b.zmin  = '1;
        b.zmax  = '0;
        return b;
    endfunction

endpackage

// File: rtl/cluster_bbox_unit_if.sv
// Point-memory read port plus the outgoing cluster-record stream.
interface cluster_bbox_unit_if;
    import dbscan_pkg::*;

    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic [COORD_W-1:0] rd_z;
    logic [LABEL_W-1:0] rd_label;

    logic               out_valid;
    logic               out_ready;
    logic [LABEL_W-1:0] out_label;
    logic [CNT_W-1:0]   out_count;
    logic [COORD_W-1:0] out_xmin;
    logic [COORD_W-1:0] out_xmax;
    logic [COORD_W-1:0] out_ymin;
    logic [COORD_W-1:0] out_ymax;
    logic [COORD_W-1:0] out_zmin;
    logic [COORD_W-1:0] out_zmax;

    modport master (
        output rd_en, rd_addr, out_valid, out_label, out_count,
               out_xmin, out_xmax, out_ymin, out_ymax, out_zmin, out_zmax,
        input  rd_x, rd_y, rd_z, rd_label, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_valid, out_label, out_count,
               out_xmin, out_xmax, out_ymin, out_ymax, out_zmin, out_zmax,
        output rd_x, rd_y, rd_z, rd_label, out_ready
    );

endinterface

// File: rtl/bbox_accum.sv
// One cluster table entry: point count and per-axis min/max, updated in a
// single cycle whenever a point carrying this entry's label arrives.
module bbox_accum
    import dbscan_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               we,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] z,
    output bbox_t              entry
);

    bbox_t entry_q;
    bbox_t entry_d;

    // Next entry value: clear on a new scan, otherwise fold in the incoming point
    always_comb begin
        entry_d = entry_q;
        if (clr) begin
            entry_d = bbox_empty();
        end else if (we) begin
            entry_d.count = entry_q.count + CNT_W'(1);
            if (x < entry_q.xmin) entry_d.xmin = x;
            if (x > entry_q.xmax) entry_d.xmax = x;
            if (y < entry_q.ymin) entry_d.ymin = y;
            if (y > entry_q.ymax) entry_d.ymax = y;
            if (z < entry_q.zmin) entry_d.zmin = z;
            if (z > entry_q.zmax) entry_d.zmax = z;
        end
    end

    // Entry register, returned to the empty state by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) entry_q <= bbox_empty();
        else      entry_q <= entry_d;
    end

    assign entry = entry_q;

endmodule

// File: rtl/cluster_bbox_unit.sv
// Scans point memory after clustering, builds a bounding box and count per
// cluster label, counts noise points, then streams one record per non-empty
// cluster in ascending label order.
module cluster_bbox_unit
    import dbscan_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    cluster_bbox_unit_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     noise_count
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [IDX_W-1:0]   eidx_q, eidx_d;
    logic [CNT_W-1:0]   noise_q, noise_d;
    logic               pend_q, pend_d;

    bbox_t              table_w [MAX_CLUSTERS];
    bbox_t              cur;
    logic [MAX_CLUSTERS-1:0] we;
    logic               clr;
    logic               is_noise;
    logic               emit_adv;
    logic               emit_last;

    // Decode the returning read datum and the entry currently being emitted
    always_comb begin
        clr       = (state_q == IDLE) && start;
        cur       = table_w[eidx_q];
        for (int i = 0; i < MAX_CLUSTERS; i++) begin
            we[i] = pend_q && (bus.rd_label == LABEL_W'(i + 1));
        end
        is_noise  = pend_q && ((bus.rd_label == LABEL_W'(NOISE_LABEL)) ||
                               (bus.rd_label > LABEL_W'(MAX_CLUSTERS)));
        emit_adv  = (state_q == EMIT) && ((cur.count == '0) || bus.out_ready);
        emit_last = (eidx_q == IDX_W'(MAX_CLUSTERS - 1));
    end

    genvar g;
    generate
        for (g = 0; g < MAX_CLUSTERS; g++) begin : g_entry
            bbox_accum u_entry (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .we    (we[g]),
                .x     (bus.rd_x),
                .y     (bus.rd_y),
                .z     (bus.rd_z),
                .entry (table_w[g])
            );
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (addr_q == ADDR_W'(N_POINTS - 1)) state_d = DRAIN;
            DRAIN:   state_d = EMIT;
            EMIT:    if (emit_adv && emit_last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: read address, emit index, noise counter, read-pending flag
    always_comb begin
        addr_d  = addr_q;
        eidx_d  = eidx_q;
        noise_d = noise_q;
        pend_d  = (state_q == SCAN);
        if (clr) begin
            addr_d  = '0;
            eidx_d  = '0;
            noise_d = '0;
        end else begin
            if (state_q == SCAN) addr_d = addr_q + ADDR_W'(1);
            if (is_noise) noise_d = noise_q + CNT_W'(1);
            if (emit_adv && !emit_last) eidx_d = eidx_q + IDX_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            eidx_q  <= '0;
            noise_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            eidx_q  <= eidx_d;
            noise_q <= noise_d;
            pend_q  <= pend_d;
        end
    end

    // FSM outputs: read strobe, record stream and status
    always_comb begin
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.out_valid = 1'b0;
        bus.out_label = '0;
        bus.out_count = '0;
        bus.out_xmin  = '0;
        bus.out_xmax  = '0;
        bus.out_ymin  = '0;
        bus.out_ymax  = '0;
        bus.out_zmin  = '0;
        bus.out_zmax  = '0;
        busy          = (state_q == SCAN) || (state_q == DRAIN) || (state_q == EMIT);
        done          = (state_q == FIN);
        noise_count   = noise_q;
        if (state_q == SCAN) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = addr_q;
        end
        if ((state_q == EMIT) && (cur.count != '0)) begin
            bus.out_valid = 1'b1;
            bus.out_label = LABEL_W'(eidx_q) + LABEL_W'(1);
            bus.out_count = cur.count;
            bus.out_xmin  = cur.xmin;
            bus.out_xmax  = cur.xmax;
            bus.out_ymin  = cur.ymin;
            bus.out_ymax  = cur.ymax;
            bus.out_zmin  = cur.zmin;
            bus.out_zmax  = cur.zmax;
        end
    end

endmodule

// File: tb/tb_cluster_bbox_unit.sv
// Directed testbench for cluster_bbox_unit: point-memory model, record checks
// against hand-computed boxes, handshake stability, noise counting and reset abort.
module tb_cluster_bbox_unit;
    import dbscan_pkg::*;

    typedef logic [55:0] rec_t;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic [CNT_W-1:0] noise_count;

    int checks;
    int fails;

    logic [COORD_W-1:0] mem_x [16];
    logic [COORD_W-1:0] mem_y [16];
    logic [COORD_W-1:0] mem_z [16];
    logic [LABEL_W-1:0] mem_l [16];

    rec_t exp_q [$];

    cluster_bbox_unit_if bus();

    cluster_bbox_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .noise_count (noise_count)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Point memory with one-cycle read latency
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_x     <= mem_x[bus.rd_addr];
            bus.rd_y     <= mem_y[bus.rd_addr];
            bus.rd_z     <= mem_z[bus.rd_addr];
            bus.rd_label <= mem_l[bus.rd_addr];
        end
    end

    function automatic rec_t mk(input int l, input int c, input int xn, input int xx,
                                input int yn, input int yx, input int zn, input int zx);
        return {4'(l), 4'(c), 8'(xn), 8'(xx), 8'(yn), 8'(yx), 8'(zn), 8'(zx)};
    endfunction

    function automatic rec_t cur_rec();
        return {bus.out_label, bus.out_count, bus.out_xmin, bus.out_xmax,
                bus.out_ymin, bus.out_ymax, bus.out_zmin, bus.out_zmax};
    endfunction

    // Loads the nine reference points; mode 0 = three clusters, 1 = with noise, 2 = all noise
    task automatic load_points(input int mode);
        int px [9] = '{10, 13, 8, 50, 52, 48, 90, 88, 93};
        int py [9] = '{10, 12, 15, 50, 48, 55, 20, 23, 18};
        int pz [9] = '{10, 9, 11, 50, 53, 49, 70, 72, 68};
        for (int i = 0; i < 16; i++) begin
            mem_x[i] = '0; mem_y[i] = '0; mem_z[i] = '0; mem_l[i] = '0;
        end
        for (int i = 0; i < 9; i++) begin
            mem_x[i] = 8'(px[i]);
            mem_y[i] = 8'(py[i]);
            mem_z[i] = 8'(pz[i]);
            mem_l[i] = (mode == 2) ? 4'd0 : 4'(i / 3 + 1);
        end
        if (mode == 1) begin
            mem_l[4] = 4'd0;
            mem_l[7] = 4'd0;
            mem_l[2] = 4'd12;
        end
    endtask

    // Runs one full scan and checks every record, handshake stability and completion
    task automatic run_scan(input string name, input int ready_mode, input int restart_at,
                            input logic [CNT_W-1:0] exp_noise, input logic exp_records);
        int cyc = 0;
        int first_valid = -1;
        int done_cnt = 0;
        int rd_cnt = 0;
        int addr_err = 0;
        int unstable = 0;
        int post = -1;
        logic hold = 1'b0;
        rec_t held = '0;
        rec_t got;
        rec_t want;
        @(negedge clk);
        start = 1'b1;
        while (cyc < 300 && post != 0) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
            bus.out_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (bus.rd_en) begin
                if (bus.rd_addr !== ADDR_W'(rd_cnt)) addr_err++;
                rd_cnt++;
            end
            if (hold && (!bus.out_valid || cur_rec() !== held)) unstable++;
            if (bus.out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (bus.out_ready) begin
                    got = cur_rec();
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("[TB] FAIL %s unexpected record: got %h, required none", name, got);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            fails++;
                            $display("[TB] FAIL %s record: got %h, required %h", name, got, want);
                        end
                    end
                end
            end
            hold = bus.out_valid && !bus.out_ready;
            held = cur_rec();
            if (done) begin
                done_cnt++;
                if (post < 0) post = 4;
            end
            if (post > 0) post--;
        end
        start = 1'b0;
        bus.out_ready = 1'b0;

        checks++;
        if (done_cnt !== 1) begin
            fails++;
            $display("[TB] FAIL %s done pulses: got %0d, required 1", name, done_cnt);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("[TB] FAIL %s missing records: got %0d left, required 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (rd_cnt !== N_POINTS || addr_err !== 0) begin
            fails++;
            $display("[TB] FAIL %s read sequence: got %0d reads %0d bad, required %0d reads 0 bad",
                     name, rd_cnt, addr_err, N_POINTS);
        end
        checks++;
        if (unstable !== 0) begin
            fails++;
            $display("[TB] FAIL %s stall stability: got %0d unstable cycles, required 0", name, unstable);
        end
        checks++;
        if (noise_count !== exp_noise) begin
            fails++;
            $display("[TB] FAIL %s noise_count: got %0d, required %0d", name, noise_count, exp_noise);
        end
        checks++;
        if (exp_records ? (first_valid < N_POINTS + 2) : (first_valid != -1)) begin
            fails++;
            $display("[TB] FAIL %s first valid cycle: got %0d, required %s", name, first_valid,
                     exp_records ? ">= 11" : "none");
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s busy after done: got %b, required 0", name, busy);
        end
    endtask

    task automatic push_base();
        exp_q.push_back(mk(1, 3, 8, 13, 10, 15, 9, 11));
        exp_q.push_back(mk(2, 3, 48, 52, 48, 55, 49, 53));
        exp_q.push_back(mk(3, 3, 88, 93, 18, 23, 68, 72));
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.rd_en !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || noise_count !== '0 || bus.rd_addr !== '0) begin
            fails++;
            $display("[TB] FAIL reset outputs: got valid=%b rd_en=%b busy=%b done=%b noise=%0d addr=%0d, required all 0",
                     bus.out_valid, bus.rd_en, busy, done, noise_count, bus.rd_addr);
        end
    endtask

    task automatic test_three_clusters();
        load_points(0);
        push_base();
        run_scan("three_clusters", 0, 0, 4'd0, 1'b1);
    endtask

    task automatic test_ready_toggle();
        load_points(0);
        push_base();
        run_scan("ready_toggle", 1, 0, 4'd0, 1'b1);
    endtask

    task automatic test_noise();
        load_points(1);
        exp_q.push_back(mk(1, 2, 10, 13, 10, 12, 9, 10));
        exp_q.push_back(mk(2, 2, 48, 50, 50, 55, 49, 50));
        exp_q.push_back(mk(3, 2, 90, 93, 18, 20, 68, 70));
        run_scan("noise", 0, 0, 4'd3, 1'b1);
    endtask

    task automatic test_all_noise();
        load_points(2);
        run_scan("all_noise", 0, 0, 4'd9, 1'b0);
    endtask

    task automatic test_back_to_back();
        load_points(0);
        push_base();
        run_scan("restart_in_scan", 0, 4, 4'd0, 1'b1);
    endtask

    task automatic test_reset_mid_emit();
        int wait_cnt = 0;
        int done_cnt = 0;
        load_points(0);
        bus.out_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!bus.out_valid && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_mid_emit reach emit: got valid=%b, required 1", bus.out_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_mid_emit outputs: got valid=%b busy=%b done=%b, required 0 0 0",
                     bus.out_valid, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_mid_emit after abort: got done=%0d busy=%b, required 0 0",
                     done_cnt, busy);
        end
    endtask

    // Test sequence
    initial begin
        checks = 0;
        fails = 0;
        rst = 1'b0;
        start = 1'b0;
        bus.out_ready = 1'b0;
        bus.rd_x = '0;
        bus.rd_y = '0;
        bus.rd_z = '0;
        bus.rd_label = '0;
        load_points(0);
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_three_clusters();
        test_ready_toggle();
        test_noise();
        test_all_noise();
        test_back_to_back();
        test_reset_mid_emit();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
